// File: rtl/e_digit_out.sv
// rtl/e_digit_out.sv - fixed-point result snapshot to BCD digit stream, MSD first
// Fraction digits come from word-serial multiply-by-10 over the snapshot.
module e_digit_out #(
  parameter int WORDS      = 32,
  parameter int NUM_DIGITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] in_data [0:WORDS-1],
  output logic        busy,
  output logic [3:0]  digit,
  output logic        digit_valid,
  input  logic        digit_ready,
  output logic        digit_last,
  output logic        int_ovf,
  output logic        done
);

  localparam int IDX_W = (WORDS > 2) ? $clog2(WORDS - 1) : 1;
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS);

  typedef enum logic [2:0] {IDLE, EMIT_INT, MUL, EMIT, DONE} state_t;

  state_t           state, state_n;
  logic [15:0]      frac [0:WORDS-2];
  logic [IDX_W-1:0] idx;
  logic [3:0]       carry;
  logic [CNT_W-1:0] dig_cnt;
  logic [3:0]       digit_r;
  logic [19:0]      prod;

  // x*10 as (x<<3)+(x<<1); carry is at most 9 so the sum fits 20 bits
  assign prod = ({4'd0, frac[idx]} << 3) + ({4'd0, frac[idx]} << 1) + {16'd0, carry};

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (start) state_n = EMIT_INT;
      EMIT_INT: if (digit_ready) state_n = MUL;
      MUL:      if (idx == LAST_IDX) state_n = EMIT;
      EMIT:     if (digit_ready) state_n = (dig_cnt == LAST_CNT) ? DONE : MUL;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < WORDS - 1; k++) frac[k] <= 16'd0;
      idx     <= '0;
      carry   <= 4'd0;
      dig_cnt <= '0;
      digit_r <= 4'd0;
      int_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          for (int k = 0; k < WORDS - 1; k++) frac[k] <= in_data[k];
          idx     <= '0;
          carry   <= 4'd0;
          dig_cnt <= '0;
          int_ovf <= (in_data[WORDS-1] >= 16'd10);
          digit_r <= (in_data[WORDS-1] >= 16'd10) ? 4'hF : in_data[WORDS-1][3:0];
        end
        MUL: begin
          frac[idx] <= prod[15:0];
          if (idx == LAST_IDX) begin
            digit_r <= prod[19:16];
            carry   <= 4'd0;
            idx     <= '0;
            dig_cnt <= dig_cnt + 1'b1;
          end else begin
            carry <= prod[19:16];
            idx   <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign digit_valid = (state == EMIT_INT) || (state == EMIT);
  assign digit_last  = (state == EMIT) && (dig_cnt == LAST_CNT);
  assign done        = (state == DONE);
  assign digit       = digit_r;

endmodule

// File: tb/tb_e_digit_out.sv
// tb/tb_e_digit_out.sv - randomized self-checking bench for e_digit_out
// Expected digits come from exact big-number arithmetic on the whole fraction.
module tb_e_digit_out;

  localparam int WORDS = 4;
  localparam int NUM_DIGITS = 8;
  localparam int FB = 16 * (WORDS - 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] in_data [0:WORDS-1];
  logic        busy;
  logic [3:0]  digit;
  logic        digit_valid;
  logic        digit_ready = 1'b1;
  logic        digit_last;
  logic        int_ovf;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  e_digit_out #(.WORDS(WORDS), .NUM_DIGITS(NUM_DIGITS)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .busy(busy),
    .digit(digit), .digit_valid(digit_valid), .digit_ready(digit_ready),
    .digit_last(digit_last), .int_ovf(int_ovf), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic load(input logic [15:0] iv, input logic [FB-1:0] fv);
    for (int k = 0; k < WORDS - 1; k++) in_data[k] = fv[16*k +: 16];
    in_data[WORDS-1] = iv;
  endtask

  task automatic wait_valid(output int cyc, output bit ok);
    cyc = 0;
    while (!digit_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    ok = digit_valid;
  endtask

  // Full conversion with optional stall on one digit and optional start injected mid-MUL
  task automatic run_conv(input logic [15:0] iv, input logic [FB-1:0] fv,
                          input int stall_d, input int stall_n, input bit inject);
    logic [3:0]    exp_d [0:NUM_DIGITS];
    logic [FB+3:0] f;
    int cyc;
    bit ok;
    exp_d[0] = (iv >= 16'd10) ? 4'hF : iv[3:0];
    f = {4'd0, fv};
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      f = f * 10;
      exp_d[k] = f[FB+3:FB];
      f[FB+3:FB] = 4'd0;
    end
    @(negedge clk);
    load(iv, fv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    load($urandom, {$urandom, $urandom});
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b want 1", busy); end
    for (int d = 0; d <= NUM_DIGITS; d++) begin
      cyc = 0;
      while (!digit_valid && cyc < 50) begin
        @(negedge clk);
        cyc++;
        if (inject && d == 1 && cyc == 1) begin
          start = 1'b1;
          load($urandom, {$urandom, $urandom});
        end else begin
          start = 1'b0;
        end
      end
      n_tests++;
      if (!digit_valid) begin
        n_fail++; $display("FAIL timeout digit %0d: no digit_valid", d);
        return;
      end
      n_tests++;
      if (cyc !== ((d == 0) ? 0 : WORDS - 1)) begin
        n_fail++; $display("FAIL spacing digit %0d: got %0d cycles want %0d", d, cyc, (d == 0) ? 0 : WORDS - 1);
      end
      if (d == stall_d) begin
        digit_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          n_tests++;
          if (digit_valid !== 1'b1 || digit !== exp_d[d]) begin
            n_fail++; $display("FAIL stall digit %0d: valid %b digit %h want 1 %h", d, digit_valid, digit, exp_d[d]);
          end
        end
        digit_ready = 1'b1;
      end
      n_tests++;
      if (digit !== exp_d[d] || digit_last !== (d == NUM_DIGITS)) begin
        n_fail++; $display("FAIL digit %0d: got %h last %b want %h last %b", d, digit, digit_last, exp_d[d], d == NUM_DIGITS);
      end
      n_tests++;
      if (int_ovf !== (iv >= 16'd10)) begin
        n_fail++; $display("FAIL int_ovf digit %0d: got %b want %b", d, int_ovf, iv >= 16'd10);
      end
      @(negedge clk);
    end
    n_tests++;
    if (done !== 1'b1 || digit_valid !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse: done %b valid %b want 1 0", done, digit_valid);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL after_done: done %b busy %b want 0 0", done, busy);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    load(16'd0, '0);
    #1;
    n_tests++;
    if ({busy, digit_valid, digit_last, done, int_ovf, digit} !== 9'b0) begin
      n_fail++; $display("FAIL reset_state: got %b want 0", {busy, digit_valid, digit_last, done, int_ovf, digit});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    run_conv(16'd2, 48'h8000_0000_0000, -1, 0, 1'b0);
    run_conv(16'd0, 48'h5555_5555_5555, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure;
    run_conv(16'd2, 48'h8000_0000_0000, 1, 5, 1'b0);
    run_conv(16'd7, {$urandom, $urandom}, 0, 3, 1'b0);
  endtask

  task automatic test_int_ovf;
    run_conv(16'd12, {$urandom, $urandom}, -1, 0, 1'b0);
    run_conv(16'd3, {$urandom, $urandom}, -1, 0, 1'b0);
  endtask

  task automatic test_start_while_busy;
    run_conv(16'd1, {$urandom, $urandom}, -1, 0, 1'b1);
  endtask

  task automatic test_random;
    for (int r = 0; r < 8; r++) begin
      run_conv(16'($urandom_range(0, 20)), {$urandom, $urandom},
               $urandom_range(0, NUM_DIGITS + 3), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit ok;
    @(negedge clk);
    load(16'd12, {$urandom, $urandom});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      wait_valid(cyc, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL reset_mid timeout digit %0d", d); return; end
      @(negedge clk);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, digit_valid, digit_last, done, int_ovf, digit} !== 9'b0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %b want 0", {busy, digit_valid, digit_last, done, int_ovf, digit});
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_conv(16'd2, 48'h8000_0000_0000, -1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_int_ovf();
    test_start_while_busy();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
